tpu_skew_feeder: RTL and testbench

TPU_SKEW_FEEDER -- requirements
Module: tpu_skew_feeder

---
 rtl/tpu_skew_feeder_if.sv | 34 +++
 rtl/tpu_skew_feeder.sv | 148 ++++++++++++++
 tb/tb_tpu_skew_feeder.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_skew_feeder_if.sv
// rtl/tpu_skew_feeder_if.sv - tile-load and run-control bus for the skew feeder
// Purpose: groups the tile write port, run control and skewed lane outputs.
// Signals:
//   wr_en/wr_row/wr_data : write one DIM-element tile row (column c at [c*BITS_AB +: BITS_AB])
//   start/hold           : request a stream run / stall the stream
//   a_out                : skewed lanes (lane i at [i*BITS_AB +: BITS_AB])
//   mac_en/busy/done     : MAC enable, run in progress, one-cycle run-complete pulse
// Modports: master drives the requests, slave is the feeder.
interface tpu_skew_feeder_if #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 4
);
    localparam int ROW_W = (DIM > 1) ? $clog2(DIM) : 1;

    logic                     wr_en;
    logic [ROW_W-1:0]         wr_row;
    logic [DIM*BITS_AB-1:0]   wr_data;
    logic                     start;
    logic                     hold;
    logic [DIM*BITS_AB-1:0]   a_out;
    logic                     mac_en;
    logic                     busy;
    logic                     done;

    modport master (
        output wr_en, wr_row, wr_data, start, hold,
        input  a_out, mac_en, busy, done
    );

    modport slave (
        input  wr_en, wr_row, wr_data, start, hold,
        output a_out, mac_en, busy, done
    );
endinterface

// File: rtl/tpu_skew_feeder.sv
// rtl/tpu_skew_feeder.sv - diagonal-skew operand feeder for a DIM x DIM systolic array
// Purpose: buffers a DIM x DIM signed tile and streams it into the array rows with a
//          one-step skew per lane, then drains the array with zero operands.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (aborts a run, clears the tile)
//   bus  : tpu_skew_feeder_if.slave (tile writes, start/hold, a_out/mac_en/busy/done)
module tpu_skew_feeder #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 4
) (
    input  logic                clk,
    input  logic                rst,
    tpu_skew_feeder_if.slave    bus
);
    localparam int STEP_W = (3*DIM-2 > 1) ? $clog2(3*DIM-2) : 1;
    localparam logic [STEP_W-1:0] LAST_STREAM = STEP_W'(2*DIM-2);
    localparam logic [STEP_W-1:0] LAST_STEP   = STEP_W'(3*DIM-3);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    // r_step is the step currently presented on a_out/mac_en
    logic [STEP_W-1:0]         r_step;
    logic [STEP_W-1:0]         w_step_nxt;
    logic [STEP_W-1:0]         w_t;
    logic [DIM*BITS_AB-1:0]    r_a_out;
    logic [DIM*BITS_AB-1:0]    w_a_nxt;
    logic [DIM*BITS_AB-1:0]    w_lanes;
    logic                      r_mac_en;
    logic                      w_mac_nxt;
    logic                      r_done;
    logic                      w_done_nxt;
    logic                      w_load;
    logic                      w_wr;

    logic signed [BITS_AB-1:0] r_mat      [DIM][DIM];
    logic signed [BITS_AB-1:0] w_mat_view [DIM][DIM];

    assign w_wr = (r_state == S_IDLE) && bus.wr_en;

    // Tile as it will be after this edge; lets a write coinciding with start
    // feed step 0 with the new row.
    always_comb begin
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                if (w_wr && (int'(bus.wr_row) == r)) begin
                    w_mat_view[r][c] = bus.wr_data[c*BITS_AB +: BITS_AB];
                end else begin
                    w_mat_view[r][c] = r_mat[r][c];
                end
            end
        end
    end

    // Step about to be loaded into the output registers.
    assign w_t = (r_state == S_IDLE) ? '0 : r_step + 1'b1;

    // Lane i carries column t-i of row i; FLUSH steps present zeros.
    always_comb begin
        w_lanes = '0;
        if (w_t <= LAST_STREAM) begin
            for (int i = 0; i < DIM; i++) begin
                for (int c = 0; c < DIM; c++) begin
                    if (int'(w_t) == i + c) begin
                        w_lanes[i*BITS_AB +: BITS_AB] = w_mat_view[i][c];
                    end
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_a_nxt     = r_a_out;
        w_mac_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_a_nxt = '0;
                if (bus.start) begin
                    w_state_nxt = S_STREAM;
                    w_step_nxt  = '0;
                    w_load      = 1'b1;
                end
            end
            S_STREAM, S_FLUSH: begin
                // hold: state, step and a_out freeze; mac_en drops
                if (!bus.hold) begin
                    if (r_step == LAST_STEP) begin
                        w_state_nxt = S_IDLE;
                        w_a_nxt     = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_step_nxt  = w_t;
                        w_state_nxt = (w_t > LAST_STREAM) ? S_FLUSH : S_STREAM;
                        w_load      = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_load) begin
            w_a_nxt   = w_lanes;
            w_mac_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_step   <= '0;
            r_a_out  <= '0;
            r_mac_en <= 1'b0;
            r_done   <= 1'b0;
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    r_mat[r][c] <= '0;
                end
            end
        end else begin
            r_state  <= w_state_nxt;
            r_step   <= w_step_nxt;
            r_a_out  <= w_a_nxt;
            r_mac_en <= w_mac_nxt;
            r_done   <= w_done_nxt;
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    r_mat[r][c] <= w_mat_view[r][c];
                end
            end
        end
    end

    assign bus.a_out  = r_a_out;
    assign bus.mac_en = r_mac_en;
    assign bus.busy   = (r_state != S_IDLE);
    assign bus.done   = r_done;
endmodule

// File: tb/tb_tpu_skew_feeder.sv
// tb/tb_tpu_skew_feeder.sv - self-checking bench for tpu_skew_feeder
module tb_tpu_skew_feeder;
    localparam int BITS_AB = 8;
    localparam int DIM     = 4;
    localparam int W       = DIM*BITS_AB;
    localparam int LAST    = 3*DIM-3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tpu_skew_feeder_if #(.BITS_AB(BITS_AB), .DIM(DIM)) bus ();

    tpu_skew_feeder #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural reference: tile contents, run position and expected outputs.
    logic [7:0]   m_mat [DIM][DIM];
    bit           m_run = 1'b0;
    int           m_k   = 0;
    logic [W-1:0] e_a;
    bit           e_mac, e_busy, e_done;

    logic [W-1:0] seen [64];
    logic [W-1:0] exp29 [10];

    typedef struct {
        bit           r;
        bit           w;
        logic [1:0]   row;
        logic [W-1:0] d;
        bit           s;
        bit           h;
        logic [W-1:0] ea;
        bit           emac;
        bit           ebusy;
        bit           edone;
    } vec_t;

    vec_t tbl [$];

    function automatic void add(input bit r, input bit w, input logic [1:0] row,
                                input logic [W-1:0] d, input bit s, input bit h,
                                input logic [W-1:0] ea, input bit em, input bit eb,
                                input bit ed);
        vec_t v;
        v.r = r; v.w = w; v.row = row; v.d = d; v.s = s; v.h = h;
        v.ea = ea; v.emac = em; v.ebusy = eb; v.edone = ed;
        tbl.push_back(v);
    endfunction

    // Lane i at step t is mat[i][t-i] when that column exists, else 0.
    function automatic logic [W-1:0] exp_vec(input int t);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < DIM; i++) begin
            if (t - i >= 0 && t - i < DIM) v[i*BITS_AB +: BITS_AB] = m_mat[i][t-i];
        end
        return v;
    endfunction

    function automatic void model_step(input bit r, input bit w, input logic [1:0] row,
                                       input logic [W-1:0] d, input bit s, input bit h);
        if (r) begin
            for (int i = 0; i < DIM; i++)
                for (int c = 0; c < DIM; c++) m_mat[i][c] = 8'h00;
            m_run = 1'b0; m_k = 0;
            e_a = '0; e_mac = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            return;
        end
        e_done = 1'b0;
        if (!m_run) begin
            if (w) begin
                for (int c = 0; c < DIM; c++) m_mat[row][c] = d[c*BITS_AB +: BITS_AB];
            end
            if (s) begin
                m_run = 1'b1; m_k = 0;
                e_a = exp_vec(0); e_mac = 1'b1; e_busy = 1'b1;
            end else begin
                e_a = '0; e_mac = 1'b0; e_busy = 1'b0;
            end
        end else if (h) begin
            e_mac = 1'b0;
        end else if (m_k == LAST) begin
            m_run = 1'b0;
            e_a = '0; e_mac = 1'b0; e_busy = 1'b0; e_done = 1'b1;
        end else begin
            m_k++;
            e_a = exp_vec(m_k); e_mac = 1'b1;
        end
    endfunction

    task automatic cyc(input bit r, input bit w, input logic [1:0] row,
                       input logic [W-1:0] d, input bit s, input bit h);
        rst         = r;
        bus.wr_en   = w;
        bus.wr_row  = row;
        bus.wr_data = d;
        bus.start   = s;
        bus.hold    = h;
        @(negedge clk);
        model_step(r, w, row, d, s, h);
    endtask

    task automatic chk(input string name, input logic [W-1:0] ea, input bit em,
                       input bit eb, input bit ed);
        checks++;
        if (bus.a_out !== ea || bus.mac_en !== em || bus.busy !== eb || bus.done !== ed) begin
            failures++;
            $display("FAIL %s: got a_out=%h mac_en=%b busy=%b done=%b, expected a_out=%h mac_en=%b busy=%b done=%b",
                     name, bus.a_out, bus.mac_en, bus.busy, bus.done, ea, em, eb, ed);
        end
    endtask

    task automatic chk_model(input string name);
        chk(name, e_a, e_mac, e_busy, e_done);
    endtask

    task automatic expect_eq(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Starts a run and follows it until done (or a planted reset), with optional
    // hold window, busy-time write+start poke and mid-run reset. Cycle n is the
    // n-th cycle after the start edge; seen[n] records a_out in that cycle.
    task automatic run_count(input int hold_at, input int hold_len, input int poke_at,
                             input int rst_at, output int done_cyc, output int mac_cnt);
        bit h, r, w;
        done_cyc = -1;
        mac_cnt  = 0;
        for (int j = 0; j < 64; j++) seen[j] = '0;
        cyc(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b0);
        chk_model("run_start");
        seen[1] = bus.a_out;
        if (bus.mac_en) mac_cnt++;
        for (int n = 1; n < 40; n++) begin
            h = (n > hold_at) && (n <= hold_at + hold_len);
            r = (n == rst_at);
            w = (n == poke_at);
            cyc(r, w, 2'd0, {DIM{8'h7F}}, w, h);
            chk_model("run_step");
            seen[n+1] = bus.a_out;
            if (bus.mac_en) mac_cnt++;
            if (bus.done) begin
                done_cyc = n + 1;
                break;
            end
            if (r) break;
        end
    endtask

    initial begin
        int dc, mc;
        logic [W-1:0] acc;
        bit r, w, s, h;
        logic [1:0] row;
        logic [W-1:0] d;

        exp29 = '{32'h00000001, 32'h00000502, 32'h00090603, 32'h0D0A0704, 32'h0E0B0800,
                  32'h0F0C0000, 32'h10000000, 32'h00000000, 32'h00000000, 32'h00000000};

        // Reset with competing inputs, tile load of 4r+c+1, one full run.
        add(1, 1, 0, 32'hFFFFFFFF, 1, 0, 32'h0, 0, 0, 0);
        add(1, 1, 0, 32'hFFFFFFFF, 1, 1, 32'h0, 0, 0, 0);
        add(0, 0, 0, 32'h0,        0, 0, 32'h0, 0, 0, 0);
        add(0, 1, 0, 32'h04030201, 0, 1, 32'h0, 0, 0, 0);
        add(0, 1, 1, 32'h08070605, 0, 0, 32'h0, 0, 0, 0);
        add(0, 1, 2, 32'h0C0B0A09, 0, 0, 32'h0, 0, 0, 0);
        add(0, 1, 3, 32'h100F0E0D, 0, 0, 32'h0, 0, 0, 0);
        add(0, 0, 0, 32'h0,        1, 0, 32'h00000001, 1, 1, 0);
        add(0, 0, 0, 32'h0,        0, 0, 32'h00000502, 1, 1, 0);
        add(0, 0, 0, 32'h0,        0, 0, 32'h00090603, 1, 1, 0);
        add(0, 0, 0, 32'h0,        0, 0, 32'h0D0A0704, 1, 1, 0);
        add(0, 0, 0, 32'h0,        0, 0, 32'h0E0B0800, 1, 1, 0);
        add(0, 0, 0, 32'h0,        0, 0, 32'h0F0C0000, 1, 1, 0);
        add(0, 0, 0, 32'h0,        0, 0, 32'h10000000, 1, 1, 0);
        add(0, 0, 0, 32'h0,        0, 0, 32'h00000000, 1, 1, 0);
        add(0, 0, 0, 32'h0,        0, 0, 32'h00000000, 1, 1, 0);
        add(0, 0, 0, 32'h0,        0, 0, 32'h00000000, 1, 1, 0);
        add(0, 0, 0, 32'h0,        0, 0, 32'h00000000, 0, 0, 1);
        add(0, 0, 0, 32'h0,        0, 0, 32'h00000000, 0, 0, 0);

        for (int k = 0; k < tbl.size(); k++) begin
            cyc(tbl[k].r, tbl[k].w, tbl[k].row, tbl[k].d, tbl[k].s, tbl[k].h);
            chk($sformatf("tbl[%0d]", k), tbl[k].ea, tbl[k].emac, tbl[k].ebusy, tbl[k].edone);
        end

        // Hold for three cycles while step 2 is presented.
        run_count(2, 3, 0, 0, dc, mc);
        expect_eq("hold_done_cycle", dc, 14);
        expect_eq("hold_mac_cycles", mc, 10);
        for (int n = 3; n <= 6; n++) expect_eq($sformatf("hold_frozen[%0d]", n), seen[n], 32'h00090603);
        expect_eq("hold_resume", seen[7], 32'h0D0A0704);

        // Busy-time write and start are ignored; next run starts in the done cycle.
        run_count(0, 0, 3, 0, dc, mc);
        expect_eq("poke_done_cycle", dc, 11);
        run_count(0, 0, 0, 0, dc, mc);
        expect_eq("rerun_done_cycle", dc, 11);
        for (int n = 1; n <= 10; n++) expect_eq($sformatf("rerun_step%0d", n-1), seen[n], exp29[n-1]);

        // Signed extremes in opposite corners.
        cyc(0, 1, 2'd0, 32'h00000080, 0, 0); chk_model("ext_wr0");
        cyc(0, 1, 2'd1, 32'h00000000, 0, 0); chk_model("ext_wr1");
        cyc(0, 1, 2'd2, 32'h00000000, 0, 0); chk_model("ext_wr2");
        cyc(0, 1, 2'd3, 32'h7F000000, 0, 0); chk_model("ext_wr3");
        run_count(0, 0, 0, 0, dc, mc);
        expect_eq("ext_lane0_step0", seen[1], 32'h00000080);
        expect_eq("ext_lane3_step6", seen[7], 32'h7F000000);
        expect_eq("ext_done_cycle", dc, 11);

        // Reset while step 5 is presented, then a run on the cleared tile.
        run_count(0, 0, 0, 6, dc, mc);
        expect_eq("midrst_no_done", dc, -1);
        run_count(0, 0, 0, 0, dc, mc);
        expect_eq("zero_run_mac", mc, 10);
        expect_eq("zero_run_done", dc, 11);
        acc = '0;
        for (int n = 1; n <= 10; n++) acc = acc | seen[n];
        expect_eq("zero_run_lanes", acc, '0);

        // Write and start in the same IDLE cycle: step 0 uses the new row.
        cyc(0, 1, 2'd0, 32'h11223344, 1, 0);
        expect_eq("wr_start_bypass", bus.a_out, 32'h00000044);
        chk_model("wr_start_model");
        for (int n = 0; n < 12; n++) begin
            cyc(0, 0, 2'd0, '0, 0, 0);
            chk_model("wr_start_run");
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            r   = ($urandom_range(0, 63) == 0);
            w   = ($urandom_range(0, 3) == 0);
            row = 2'($urandom_range(0, 3));
            d   = $urandom;
            s   = ($urandom_range(0, 5) == 0);
            h   = ($urandom_range(0, 3) == 0);
            cyc(r, w, row, d, s, h);
            chk_model("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
